// File: rtl/ctrl_decode_stage.sv
// Table-driven stage-2 decoder: assembles opcode plus optional operand from a byte stream,
// looks up a loadable control word and emits one registered {ctrl, opcode, od} packet.
module ctrl_decode_stage #(
  parameter int OPW   = 8,
  parameter int CW    = 13,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [OPW-1:0]   in_byte,
  output logic             in_ready,
  input  logic             bubble,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    ctrl_out,
  output logic [OPW-1:0]   op_out,
  output logic [OPW-1:0]   od_out,
  output logic             out_bubble,
  input  logic             tbl_we,
  input  logic [OPW-1:0]   tbl_addr,
  input  logic [CW:0]      tbl_data,
  output logic [CNT_W-1:0] issue_cnt
);

  typedef enum logic {S_OP, S_OD} state_t;

  state_t           state, state_nx;
  logic [CW:0]      tbl [2**OPW];
  logic [CW:0]      entry;
  logic [CW-1:0]    held_ctrl;
  logic [OPW-1:0]   held_op;
  logic             free, accept, pop;
  logic             load, load_bub, latch_held, clr_held;
  logic [CW-1:0]    pkt_ctrl;
  logic [OPW-1:0]   pkt_op, pkt_od;

  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] cnt);
    return cnt + 1'b1;
  endfunction

  // Decode table: not reset, written synchronously, read combinationally on in_byte.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl[tbl_addr] <= tbl_data;
  end

  always_comb entry = tbl[in_byte];

  assign free     = !out_valid || out_ready;
  assign in_ready = free && !bubble && !flush;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    state_nx   = state;
    load       = 1'b0;
    load_bub   = 1'b0;
    latch_held = 1'b0;
    clr_held   = 1'b0;
    pkt_ctrl   = '0;
    pkt_op     = '0;
    pkt_od     = '0;
    if (flush) begin
      state_nx = S_OP;
      clr_held = 1'b1;
    end else if (accept) begin
      if (state == S_OP) begin
        if (entry[CW]) begin
          latch_held = 1'b1;
          state_nx   = S_OD;
        end else begin
          load     = 1'b1;
          pkt_ctrl = entry[CW-1:0];
          pkt_op   = in_byte;
        end
      end else begin
        load     = 1'b1;
        pkt_ctrl = held_ctrl;
        pkt_op   = held_op;
        pkt_od   = in_byte;
        state_nx = S_OP;
      end
    end else if (bubble && free) begin
      load     = 1'b1;
      load_bub = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_OP;
      held_ctrl  <= '0;
      held_op    <= '0;
      out_valid  <= 1'b0;
      out_bubble <= 1'b0;
      ctrl_out   <= '0;
      op_out     <= '0;
      od_out     <= '0;
      issue_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (clr_held) begin
        held_ctrl <= '0;
        held_op   <= '0;
      end else if (latch_held) begin
        held_ctrl <= entry[CW-1:0];
        held_op   <= in_byte;
      end
      if (flush) begin
        out_valid  <= 1'b0;
        out_bubble <= 1'b0;
      end else if (load) begin
        out_valid  <= 1'b1;
        out_bubble <= load_bub;
        ctrl_out   <= pkt_ctrl;
        op_out     <= pkt_op;
        od_out     <= pkt_od;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      // A pop in the flush cycle still counts; bubbles never do.
      if (pop && !out_bubble) issue_cnt <= wrap_inc(issue_cnt);
    end
  end

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage: a packet-level model is checked every cycle,
// plus hand-computed literal checks on the documented scenarios.
module tb_ctrl_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, bubble, flush, out_ready, tbl_we;
  logic [7:0]  in_byte, tbl_addr;
  logic [13:0] tbl_data;
  logic        in_ready, out_valid, out_bubble;
  logic [12:0] ctrl_out;
  logic [7:0]  op_out, od_out;
  logic [15:0] issue_cnt;
  logic        in_ready2, out_valid2, out_bubble2;
  logic [12:0] ctrl_out2;
  logic [7:0]  op_out2, od_out2;
  logic [1:0]  issue_cnt2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ctrl_decode_stage #(.OPW(8), .CW(13), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .bubble(bubble), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_out(ctrl_out), .op_out(op_out), .od_out(od_out), .out_bubble(out_bubble),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .issue_cnt(issue_cnt));

  ctrl_decode_stage #(.OPW(8), .CW(13), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready2),
    .bubble(bubble), .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
    .ctrl_out(ctrl_out2), .op_out(op_out2), .od_out(od_out2), .out_bubble(out_bubble2),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .issue_cnt(issue_cnt2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pending opcode (or -1) plus the packet currently offered downstream.
  logic [13:0] tbl_m [256];
  int          pend;
  logic [12:0] pctrl;
  bit          m_valid, m_bub;
  logic [12:0] m_ctrl;
  logic [7:0]  m_op, m_od;
  int unsigned m_cnt;

  always @(posedge clk or posedge rst) begin
    bit m_free, m_acc, m_pop;
    logic [13:0] e;
    if (rst) begin
      pend = -1; pctrl = '0; m_valid = 0; m_bub = 0;
      m_ctrl = '0; m_op = '0; m_od = '0; m_cnt = 0;
    end else begin
      m_free = !m_valid || out_ready;
      m_acc  = in_valid && m_free && !bubble && !flush;
      m_pop  = m_valid && out_ready;
      if (m_pop && !m_bub) m_cnt++;
      if (m_pop) m_valid = 0;
      if (flush) begin
        m_valid = 0; m_bub = 0; pend = -1;
      end else if (m_acc && pend >= 0) begin
        m_valid = 1; m_bub = 0; m_ctrl = pctrl; m_op = pend[7:0]; m_od = in_byte; pend = -1;
      end else if (m_acc) begin
        e = tbl_m[in_byte];
        if (e[13]) begin
          pend = int'(in_byte); pctrl = e[12:0];
        end else begin
          m_valid = 1; m_bub = 0; m_ctrl = e[12:0]; m_op = in_byte; m_od = 8'h00;
        end
      end else if (bubble && m_free) begin
        m_valid = 1; m_bub = 1; m_ctrl = '0; m_op = '0; m_od = '0;
      end
      if (tbl_we) tbl_m[tbl_addr] = tbl_data;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, (!m_valid || out_ready) && !bubble && !flush);
      chk("out_valid", out_valid, m_valid);
      chk("out_bubble", out_bubble, m_bub);
      chk("issue_cnt", issue_cnt, m_cnt & 32'hffff);
      chk("issue_cnt_w2", issue_cnt2, m_cnt & 32'h3);
      if (m_valid) begin
        chk("ctrl_out", ctrl_out, m_ctrl);
        chk("op_out", op_out, m_op);
        chk("od_out", od_out, m_od);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1; in_byte = b;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b1; in_valid = 0; in_byte = '0; bubble = 0; flush = 0;
    out_ready = 1'b1; tbl_we = 0; tbl_addr = '0; tbl_data = '0;
    step(); step();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ctrl", ctrl_out, 13'h0);
    chk("rst_op_od", {op_out, od_out}, 16'h0);
    chk("rst_cnt", issue_cnt, 16'h0);
    rst = 1'b0;

    tbl_we = 1; tbl_addr = 8'h01; tbl_data = {1'b0, 13'h0104}; step();
    tbl_addr = 8'h03; tbl_data = {1'b1, 13'h1010}; step();
    tbl_we = 0;

    // Single-byte instruction
    send(8'h01);
    chk("t1_ctrl", ctrl_out, 13'h0104);
    chk("t1_op", op_out, 8'h01);
    chk("t1_od", od_out, 8'h00);
    chk("t1_valid", out_valid, 1'b1);
    step();
    chk("t1_cnt", issue_cnt, 16'd1);

    // Opcode with operand
    send(8'h03);
    chk("t2_nopkt", out_valid, 1'b0);
    send(8'h5A);
    chk("t2_ctrl", ctrl_out, 13'h1010);
    chk("t2_op_od", {op_out, od_out}, 16'h035A);

    // Back-pressure for three cycles with a byte waiting
    out_ready = 0; in_valid = 1; in_byte = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_op_od", {op_out, od_out}, 16'h035A);
    end
    out_ready = 1; #1;
    chk("bp_release_ready", in_ready, 1'b1);
    step(); in_valid = 0;
    chk("bp_next_op", op_out, 8'h01);
    step();

    // Bubbles between opcode and operand
    base = int'(issue_cnt);
    send(8'h03);
    bubble = 1; step();
    chk("bub_flag", out_bubble, 1'b1);
    chk("bub_ctrl", ctrl_out, 13'h0);
    step(); bubble = 0;
    send(8'h77);
    chk("bub_op_od", {op_out, od_out}, 16'h0377);
    step();
    chk("bub_cnt", int'(issue_cnt), base + 1);

    // Flush discards a pending opcode
    send(8'h03);
    flush = 1; in_valid = 1; in_byte = 8'h42; step();
    flush = 0; in_valid = 0;
    chk("flush_valid", out_valid, 1'b0);
    send(8'h01);
    chk("flush_op", op_out, 8'h01);
    chk("flush_ctrl", ctrl_out, 13'h0104);

    // Operand byte 0x00 is still an operand
    send(8'h03); send(8'h00);
    chk("od_zero", {op_out, od_out}, 16'h0300);
    chk("od_zero_valid", out_valid, 1'b1);

    // Write and accept of the same entry in one cycle
    tbl_we = 1; tbl_addr = 8'h01; tbl_data = {1'b0, 13'h1FFF};
    send(8'h01); tbl_we = 0;
    chk("wr_old_ctrl", ctrl_out, 13'h0104);
    send(8'h01);
    chk("wr_new_ctrl", ctrl_out, 13'h1FFF);
    step();

    // Counter wrap with CNT_W=2 after a fresh reset (table survives reset)
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 5; i++) send(8'h01);
    step();
    chk("wrap_cnt2", issue_cnt2, 2'd1);
    chk("wrap_cnt16", issue_cnt, 16'd5);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
